mul_sequencer: RTL and testbench

Iterative shift-add multiply controller for the execute stage. It accepts a multiply issued by the decoder (`mul_en` path) and latches both operands. It then runs a radix-2 shift-add loop with early termination, holds the pipeline with `stall_o` until the product is ready, and presents the low XLEN bits of the product (RV32M `MUL`) for one cycle. It replaces a single-cycle multiplier so the execute stage timing is set by the adder, not a 32×32 array.

---
 rtl/mul_seq_pkg.sv | 13 +
 rtl/mul_seq_datapath.sv | 48 ++++
 rtl/mul_sequencer.sv | 75 +++++++
 tb/tb_mul_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and sizing for the iterative shift-add multiply sequencer.
package mul_seq_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = $clog2(XLEN_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_seq_state_t;

endpackage

// File: rtl/mul_seq_datapath.sv
// Operand, accumulator and counter registers for the radix-2 shift-add loop.
module mul_seq_datapath
  import mul_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc,
  output logic            mplier_next_zero,
  output logic            cnt_last
);

  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [CNT_W-1:0] cnt;

  // The accumulator wraps modulo 2^XLEN; only the low product bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign mplier_next_zero = (mplier[XLEN-1:1] == '0);
  assign cnt_last         = (cnt == CNT_W'(XLEN - 1));

endmodule

// File: rtl/mul_sequencer.sv
// Execute-stage multiply controller: accepts a MUL, stalls the pipe while the
// shift-add loop runs, then presents the low XLEN product bits for one cycle.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_en_e,
  input  logic            flush_e,
  input  logic [XLEN-1:0] mul_a_e,
  input  logic [XLEN-1:0] mul_b_e,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  mul_seq_state_t state;
  logic           accept;
  logic           step;
  logic           mplier_next_zero;
  logic           cnt_last;

  assign accept = (state == IDLE) && mul_en_e && !flush_e;
  // A flushed instruction must not advance the loop so acc is left untouched.
  assign step   = (state == RUN) && !flush_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= (mul_b_e == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (flush_e) begin
            state <= IDLE;
          end else if (mplier_next_zero || cnt_last) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mul_seq_datapath #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (accept),
    .step             (step),
    .a                (mul_a_e),
    .b                (mul_b_e),
    .acc              (result_o),
    .mplier_next_zero (mplier_next_zero),
    .cnt_last         (cnt_last)
  );

  // Stall is combinational so the pipe freezes in the accept cycle itself;
  // gating with rst_n keeps it low while reset is held.
  assign stall_o        = rst_n && (accept || step);
  assign busy_o         = (state != IDLE);
  assign result_valid_o = (state == DONE) && !flush_e;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a product scoreboard and latency model.
module tb_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        mul_en_e;
  logic        flush_e;
  logic [31:0] mul_a_e;
  logic [31:0] mul_b_e;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] result_o;
  logic        result_valid_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb[$];

  mul_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mul_en_e       (mul_en_e),
    .flush_e        (flush_e),
    .mul_a_e        (mul_a_e),
    .mul_b_e        (mul_b_e),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int k_of(input logic [31:0] b);
    int k;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) k = i + 1;
    end
    return k;
  endfunction

  // Drives at the negedge and samples 1 time unit later, well away from posedge.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int exp_k;
    logic [31:0] exp_p;
    @(negedge clk);
    mul_en_e = 1'b1;
    flush_e  = 1'b0;
    mul_a_e  = a;
    mul_b_e  = b;
    #1;
    check({tag, "_t0_stall"}, 32'(stall_o), 32'd1);
    check({tag, "_t0_busy"},  32'(busy_o),  32'd0);
    exp_p = a * b;
    sb.push_back(exp_p);
    exp_k = k_of(b);
    @(negedge clk);
    mul_en_e = 1'b0;
    #1;
    lat = 1;
    while (!result_valid_o && lat < 40) begin
      if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
        check({tag, "_run_stall_busy"}, {30'd0, stall_o, busy_o}, 32'd3);
      end
      next_cycle();
      lat++;
    end
    if (!result_valid_o) begin
      check({tag, "_timeout_valid"}, 32'(result_valid_o), 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_k + 1));
      check({tag, "_done_stall"}, 32'(stall_o), 32'd0);
      check({tag, "_done_busy"},  32'(busy_o),  32'd1);
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        check({tag, "_result"}, result_o, sb.pop_front());
      end
    end
  endtask

  initial begin
    logic [31:0] held;
    rst_n    = 1'b0;
    mul_en_e = 1'b1;
    flush_e  = 1'b0;
    mul_a_e  = 32'd7;
    mul_b_e  = 32'd6;
    #12;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_result", result_o,    32'd0);
    check("rst_valid", 32'(result_valid_o), 32'd0);
    @(negedge clk);
    mul_en_e = 1'b0;
    rst_n    = 1'b1;

    do_mul("m7x6", 32'd7, 32'd6);
    held = 32'd42;
    next_cycle();
    check("hold_valid",  32'(result_valid_o), 32'd0);
    check("hold_busy",   32'(busy_o), 32'd0);
    check("hold_result", result_o, held);

    do_mul("b_zero", 32'h1234_5678, 32'd0);
    do_mul("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_mul("wrap", 32'h8000_0000, 32'd2);

    // Flush in RUN: accept at T0, flush at T5, new multiply at T6.
    @(negedge clk);
    mul_en_e = 1'b1;
    mul_a_e  = 32'd5;
    mul_b_e  = 32'h0000_FFFF;
    #1;
    check("fl_t0_stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    mul_en_e = 1'b0;
    for (int t = 1; t < 5; t++) begin
      #1;
      check("fl_run_stall", 32'(stall_o), 32'd1);
      @(negedge clk);
    end
    flush_e = 1'b1;
    #1;
    check("fl_t5_stall", 32'(stall_o), 32'd0);
    check("fl_t5_valid", 32'(result_valid_o), 32'd0);
    check("fl_t5_busy",  32'(busy_o), 32'd1);
    do_mul("after_flush", 32'd3, 32'd4);

    // Back-to-back: second accept lands right after DONE.
    do_mul("b2b_1", 32'd3, 32'd3);
    do_mul("b2b_2", 32'd10, 32'd10);

    // Flush together with accept in IDLE: no stall, nothing starts.
    @(negedge clk);
    mul_en_e = 1'b1;
    flush_e  = 1'b1;
    mul_a_e  = 32'd9;
    mul_b_e  = 32'd9;
    #1;
    check("idle_flush_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    mul_en_e = 1'b0;
    flush_e  = 1'b0;
    #1;
    check("idle_flush_busy", 32'(busy_o), 32'd0);

    // Async reset in the middle of a long run.
    @(negedge clk);
    mul_en_e = 1'b1;
    mul_a_e  = 32'hFFFF_FFFF;
    mul_b_e  = 32'hFFFF_FFFF;
    @(negedge clk);
    mul_en_e = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b0;
    mul_en_e = 1'b1;
    #1;
    check("mid_rst_stall",  32'(stall_o), 32'd0);
    check("mid_rst_busy",   32'(busy_o),  32'd0);
    check("mid_rst_result", result_o,     32'd0);
    check("mid_rst_valid",  32'(result_valid_o), 32'd0);
    @(negedge clk);
    mul_en_e = 1'b0;
    rst_n    = 1'b1;
    do_mul("post_rst", 32'd2, 32'd2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
